video_reset_seq: RTL

VIDEO_RESET_SEQ -- requirements
Module: video_reset_seq

---
 rtl/video_reset_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/video_reset_seq.sv
// video_reset_seq: sequences the video-pipeline reset from the pixel PLL lock (HOLD -> WAIT_LOCK -> STABLE -> RUN).
// Latency: reset_out falls STABLE_CYCLES+3 edges after lock is first sampled in WAIT_LOCK; rises 3 edges after a lock drop in RUN.
// Backpressure: none, free-running with no handshake; loss_count is built only when VIDEO_RESET_LOSS_COUNT_EN is defined.
module video_reset_seq #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked_i,
  output logic       reset_out,
  output logic       ready,
  output logic [1:0] state_o,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    WAIT_LOCK = 2'b01,
    STABLE    = 2'b10,
    RUN       = 2'b11
  } state_t;

  // Terminal counts, pre-truncated to the shared 16-bit counter width.
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  // Both durations must fit the 16-bit counter and be at least one cycle.
  generate
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable
      $error("video_reset_seq: STABLE_CYCLES out of range 1..65535");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
      $error("video_reset_seq: HOLD_CYCLES out of range 1..65535");
    end
  endgenerate

  logic        lk_m;
  logic        lk_s;
  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;

  // Two-flop synchroniser: lk_m is the only flop that samples the asynchronous lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= locked_i;
      lk_s <= lk_m;
    end
  end

  // State and shared cycle counter registers; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HOLD;
      cnt   <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and counter update; the counter restarts from zero on every state change.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      HOLD: begin
        // Lock is deliberately ignored so the pipeline always sees a minimum reset pulse.
        if (cnt == HOLD_LAST) begin
          state_nx = WAIT_LOCK;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_nx = STABLE;
        end
      end
      STABLE: begin
        // Any dip in lock, however short, restarts the stability window.
        if (!lk_s) begin
          state_nx = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_nx = HOLD;
        end
      end
      default: begin
        state_nx = HOLD;
      end
    endcase
    if (state_nx != state) begin
      cnt_nx = 16'd0;
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally.
  assign reset_out = (state != RUN);
  assign ready     = ~reset_out;
  assign state_o   = state;

`ifdef VIDEO_RESET_LOSS_COUNT_EN
  logic       loss_evt;
  logic [7:0] loss_q;

  // A lock loss is counted only when it knocks the domain out of RUN.
  assign loss_evt = (state == RUN) && !lk_s;

  // Saturating lock-loss counter; holds at 255 rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = 8'd0;
`endif

endmodule
